// File: rtl/pacman_pkg.sv
// Shared maze constants, state encoding and pellet helpers for the pacman blocks.
package pacman_pkg;

  localparam int unsigned MAZE_COLS     = 28;
  localparam int unsigned MAZE_ROWS     = 30;
  localparam int unsigned TILE_SHIFT    = 4;
  localparam int unsigned MAZE_X_ORIGIN = 96;
  localparam int unsigned MAZE_Y_ORIGIN = 0;
  localparam int unsigned PELLET_PTS    = 10;

  // One maze row of pellets; bit c is tile column c.
  typedef logic [MAZE_COLS-1:0] pellet_row_t;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StCleared
  } state_e;

  // Default pellet layout: a single strip of four pellets on row 1, columns 1..4.
  localparam pellet_row_t PELLET_ROM_DEFAULT [MAZE_ROWS] = '{1: 28'h000_001E, default: '0};

  // Number of pellets present in one maze row.
  function automatic logic [9:0] popcount(pellet_row_t row);
    logic [9:0] n;
    n = '0;
    for (int i = 0; i < MAZE_COLS; i++) begin
      n = n + 10'(row[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pellet_rom.sv
// Pellet layout ROM: one maze row per word, synchronous read with one cycle of latency.
module pellet_rom
  import pacman_pkg::*;
#(
  parameter pellet_row_t Contents [MAZE_ROWS] = PELLET_ROM_DEFAULT
) (
  input  logic        clk_i,
  input  logic [4:0]  addr_i,
  output pellet_row_t data_o
);

  pellet_row_t data_q;

  // Registered read; addresses past the last row return an empty row.
  always_ff @(posedge clk_i) begin
    data_q <= (addr_i < 5'(MAZE_ROWS)) ? Contents[addr_i] : '0;
  end

  assign data_o = data_q;

endmodule

// File: rtl/pellet_tracker.sv
// Pellet map keeper: loads the maze from ROM, eats pellets under the player, keeps score.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter pellet_row_t RomInit [MAZE_ROWS] = PELLET_ROM_DEFAULT
) (
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic        stop,
  input  logic        restart,
  input  logic [4:0]  q_col,
  input  logic [4:0]  q_row,
  output logic        q_pellet,
  output logic [15:0] score,
  output logic [9:0]  pellets_left,
  output logic        eat,
  output logic        level_clear,
  output logic        init_busy
);

  localparam logic [4:0] LastRow = 5'(MAZE_ROWS);

  state_e      state_q;
  logic [4:0]  row_q;
  pellet_row_t map_q [MAZE_ROWS];
  logic [15:0] score_q;
  logic [9:0]  left_q;
  logic        eat_q;

  pellet_row_t rom_data;

  pellet_rom #(
    .Contents (RomInit)
  ) u_rom (
    .clk_i  (frame_clk),
    .addr_i (row_q),
    .data_o (rom_data)
  );

  // Player tile; an 11-bit subtract exposes a position left of / above the maze as a borrow.
  logic [10:0] dx, dy;
  logic [9:0]  col_full, row_full;
  logic [4:0]  ball_col, ball_row;
  logic        in_range;
  logic        hit;

  assign dx       = {1'b0, BallX} - {1'b0, 10'(MAZE_X_ORIGIN)};
  assign dy       = {1'b0, BallY} - {1'b0, 10'(MAZE_Y_ORIGIN)};
  assign col_full = dx[9:0] >> TILE_SHIFT;
  assign row_full = dy[9:0] >> TILE_SHIFT;
  assign ball_col = col_full[4:0];
  assign ball_row = row_full[4:0];
  assign in_range = !dx[10] && !dy[10] &&
                    (col_full < 10'(MAZE_COLS)) && (row_full < 10'(MAZE_ROWS));
  assign hit      = (state_q == StRun) && !stop && in_range && map_q[ball_row][ball_col];

  // Score with saturation at full scale.
  logic [16:0] score_sum;
  logic [15:0] score_sat;

  assign score_sum = {1'b0, score_q} + 17'(PELLET_PTS);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Running pellet total while loading; ROM data lags the address by one cycle.
  logic [9:0] init_left;

  assign init_left = left_q + ((row_q != 5'd0) ? popcount(rom_data) : 10'd0);

  // Load / run / cleared sequencing with all state and the eat pulse registered.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StInit;
      row_q   <= '0;
      map_q   <= '{default: '0};
      score_q <= '0;
      left_q  <= '0;
      eat_q   <= 1'b0;
    end else begin
      eat_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (row_q != 5'd0) begin
            map_q[row_q - 5'd1] <= rom_data;
          end
          left_q <= init_left;
          if (row_q == LastRow) begin
            row_q   <= '0;
            state_q <= (init_left == 10'd0) ? StCleared : StRun;
          end else begin
            row_q <= row_q + 5'd1;
          end
        end
        StRun: begin
          if (hit) begin
            map_q[ball_row][ball_col] <= 1'b0;
            score_q                   <= score_sat;
            left_q                    <= left_q - 10'd1;
            eat_q                     <= 1'b1;
            if (left_q == 10'd1) begin
              state_q <= StCleared;
            end
          end
        end
        StCleared: begin
          if (restart) begin
            state_q <= StInit;
            row_q   <= '0;
            left_q  <= '0;
            map_q   <= '{default: '0};
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Renderer query; anything outside the maze reads as empty.
  always_comb begin
    q_pellet = 1'b0;
    if ((q_row < 5'(MAZE_ROWS)) && (q_col < 5'(MAZE_COLS))) begin
      q_pellet = map_q[q_row][q_col];
    end
  end

  assign score        = score_q;
  assign pellets_left = left_q;
  assign eat          = eat_q;
  assign level_clear  = (state_q == StCleared);
  assign init_busy    = (state_q == StInit);

endmodule

// File: tb/tb_pellet_tracker.sv
// Scoreboard bench for pellet_tracker: expected outputs queued per cycle, compared after the edge.
module tb_pellet_tracker;

  logic        Reset;
  logic        frame_clk;
  logic [9:0]  BallX, BallY;
  logic        stop, restart;
  logic [4:0]  q_col, q_row;
  logic        q_pellet;
  logic [15:0] score;
  logic [9:0]  pellets_left;
  logic        eat, level_clear, init_busy;

  pellet_tracker dut (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .BallX        (BallX),
    .BallY        (BallY),
    .stop         (stop),
    .restart      (restart),
    .q_col        (q_col),
    .q_row        (q_row),
    .q_pellet     (q_pellet),
    .score        (score),
    .pellets_left (pellets_left),
    .eat          (eat),
    .level_clear  (level_clear),
    .init_busy    (init_busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic        eat;
    logic        clr;
    logic        busy;
    logic [15:0] score;
    logic [9:0]  left;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_score  = 0;
  int          m_left   = 0;
  logic [27:0] rom_m [30];

  function automatic int bits_set(logic [27:0] v);
    int n = 0;
    for (int i = 0; i < 28; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o = {eat, level_clear, init_busy, score, pellets_left};
    return o;
  endfunction

  function automatic void push(logic e_eat, logic e_clr, logic e_busy);
    exp_t e;
    e = {e_eat, e_clr, e_busy, m_score[15:0], m_left[9:0]};
    sb.push_back(e);
  endfunction

  task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic st, input logic rs);
    BallX = x; BallY = y; stop = st; restart = rs;
    @(posedge frame_clk);
    #1;
  endtask

  // 31-cycle map reload from the bench's own copy of the ROM layout.
  task automatic run_init(input string tag);
    exp_t e;
    for (int i = 1; i <= 31; i++) begin
      if (i >= 2) m_left += bits_set(rom_m[i-2]);
      push(1'b0, (i == 31) && (m_left == 0), i < 31);
      tick(10'd0, 10'd0, 1'b0, 1'b0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 tag, i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
    end
  endtask

  task automatic check_q(input string tag, input logic [4:0] r, input logic [4:0] c,
                         input logic want);
    q_row = r; q_col = c;
    #1;
    n_checks++;
    if (q_pellet !== want) begin
      n_fail++;
      $display("FAIL %s q_pellet(%0d,%0d): got %b want %b", tag, r, c, q_pellet, want);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1;
    tick(10'd0, 10'd0, 1'b0, 1'b0);
    tick(10'd0, 10'd0, 1'b0, 1'b0);
    m_score = 0; m_left = 0;
    push(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
               eat, level_clear, init_busy, score, pellets_left,
               e.eat, e.clr, e.busy, e.score, e.left);
    end
    check_q("reset", 5'd1, 5'd2, 1'b0);
    Reset = 1'b0;
  endtask

  task automatic test_init();
    m_left = 0;
    run_init("init");
    check_q("init", 5'd1, 5'd2, 1'b1);
    check_q("init", 5'd0, 5'd0, 1'b0);
    check_q("init", 5'd1, 5'd4, 1'b1);
    check_q("init", 5'd1, 5'd5, 1'b0);
  endtask

  task automatic test_eat();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        m_score += 10; m_left -= 1;
        push(1'b1, 1'b0, 1'b0);
      end else begin
        push(1'b0, 1'b0, 1'b0);
      end
      // restart is held during the hold cycles; it must have no effect in RUN.
      tick(10'd136, 10'd24, 1'b0, i != 0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL eat[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
      if (i == 0) check_q("eat", 5'd1, 5'd2, 1'b0);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [9:0] xs [5];
    logic [9:0] ys [5];
    // left of maze, col 31, col 33 (aliases col 1), row 33 (aliases row 1), col 28
    xs = '{10'd50, 10'd600, 10'd632, 10'd120, 10'd552};
    ys = '{10'd24, 10'd24,  10'd24,  10'd536, 10'd24};
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b0, 1'b0);
      tick(xs[i], ys[i], 1'b0, 1'b0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL range[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
    end
    check_q("range", 5'd31, 5'd1, 1'b0);
    check_q("range", 5'd1, 5'd1, 1'b1);
  endtask

  task automatic test_stop();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        m_score += 10; m_left -= 1;
        push(1'b1, 1'b0, 1'b0);
      end else begin
        push(1'b0, 1'b0, 1'b0);
      end
      tick(10'd120, 10'd24, i != 3, 1'b0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stop[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
      if (i == 2) check_q("stop", 5'd1, 5'd1, 1'b1);
    end
    check_q("stop", 5'd1, 5'd1, 1'b0);
  endtask

  // Eat the two remaining pellets, idle in CLEARED, then restart.
  task automatic clear_and_restart(input string tag);
    exp_t e;
    logic [9:0] xs [5];
    xs = '{10'd152, 10'd168, 10'd136, 10'd120, 10'd0};
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        m_left -= 1;
        push(1'b1, m_left == 0, 1'b0);
      end else if (i < 4) begin
        push(1'b0, 1'b1, 1'b0);
      end else begin
        push(1'b0, 1'b0, 1'b1);
      end
      tick(xs[i], 10'd24, i == 3, i == 4);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 tag, i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
    end
  endtask

  task automatic test_clear();
    clear_and_restart("clear");
    m_left = 0;
    run_init("reload");
    check_q("reload", 5'd1, 5'd3, 1'b1);
  endtask

  task automatic test_saturation();
    exp_t e;
    force dut.score_q = 16'd65530;
    #1;
    release dut.score_q;
    #1;
    m_score = 65530;
    n_checks++;
    if (score !== 16'd65530) begin
      n_fail++;
      $display("FAIL preload: got score=%0d want score=%0d", score, m_score);
    end
    for (int i = 0; i < 2; i++) begin
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      m_left -= 1;
      push(1'b1, 1'b0, 1'b0);
      tick((i == 0) ? 10'd120 : 10'd136, 10'd24, 1'b0, 1'b0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL sat[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    exp_t e;
    clear_and_restart("preclr");
    m_left = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i >= 2) m_left += bits_set(rom_m[i-2]);
      push(1'b0, 1'b0, 1'b1);
      tick(10'd0, 10'd0, 1'b0, 1'b0);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL midinit[%0d]: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
                 i, eat, level_clear, init_busy, score, pellets_left,
                 e.eat, e.clr, e.busy, e.score, e.left);
      end
    end
    Reset = 1'b1;
    #2;
    m_score = 0; m_left = 0;
    push(1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL async_reset: got eat=%b clr=%b busy=%b score=%0d left=%0d want eat=%b clr=%b busy=%b score=%0d left=%0d",
               eat, level_clear, init_busy, score, pellets_left,
               e.eat, e.clr, e.busy, e.score, e.left);
    end
    check_q("async_reset", 5'd1, 5'd2, 1'b0);
    tick(10'd0, 10'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    run_init("rst_reload");
    check_q("rst_reload", 5'd1, 5'd2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 30; r++) rom_m[r] = '0;
    rom_m[1] = 28'h000_001E;
    Reset = 1'b1; BallX = '0; BallY = '0; stop = 1'b0; restart = 1'b0;
    q_row = '0; q_col = '0;

    test_reset();
    test_init();
    test_eat();
    test_out_of_range();
    test_stop();
    test_clear();
    test_saturation();
    test_reset_mid_init();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
